// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges MEM/WB results and buffered divider results onto the
// single register-file write port, raising a one-cycle stall when the divider starves.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_we,
  input  logic [4:0]              mem_waddr,
  input  logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_pc,
  input  logic                    div_valid,
  output logic                    div_ready,
  input  logic [4:0]              div_waddr,
  input  logic [31:0]             div_wdata,
  input  logic [31:0]             div_pc,
  output logic                    wb_we,
  output logic [4:0]              wb_waddr,
  output logic [31:0]             wb_wdata,
  output logic [31:0]             wb_pc,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT);

  logic [4:0]    q_waddr [DEPTH];
  logic [31:0]   q_wdata [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] starve;

  logic          empty, div_ok, pop, push, sel_any;
  logic [4:0]    sel_waddr;
  logic [31:0]   sel_wdata, sel_pc;

  assign empty     = (fifo_cnt == '0);
  assign div_ready = rst && (fifo_cnt < ($clog2(DEPTH)+1)'(DEPTH));
  assign div_ok    = div_valid && div_ready && (div_waddr != '0);

  always_comb begin
    pop       = 1'b0;
    push      = div_ok;
    sel_any   = 1'b0;
    sel_waddr = '0;
    sel_wdata = '0;
    sel_pc    = '0;
    if (stall_req && !empty) begin
      // mem_* is ignored here; the stalled upstream presents it again next cycle
      pop       = 1'b1;
      sel_any   = 1'b1;
      sel_waddr = q_waddr[rd_ptr];
      sel_wdata = q_wdata[rd_ptr];
      sel_pc    = q_pc[rd_ptr];
    end else if (mem_we && mem_waddr != '0) begin
      sel_any   = 1'b1;
      sel_waddr = mem_waddr;
      sel_wdata = mem_wdata;
      sel_pc    = mem_pc;
    end else if (!empty) begin
      pop       = 1'b1;
      sel_any   = 1'b1;
      sel_waddr = q_waddr[rd_ptr];
      sel_wdata = q_wdata[rd_ptr];
      sel_pc    = q_pc[rd_ptr];
    end else if (div_ok) begin
      push      = 1'b0;
      sel_any   = 1'b1;
      sel_waddr = div_waddr;
      sel_wdata = div_wdata;
      sel_pc    = div_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_waddr[wr_ptr] <= div_waddr;
      q_wdata[wr_ptr] <= div_wdata;
      q_pc[wr_ptr]    <= div_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      starve    <= '0;
      stall_req <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      wb_pc     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;

      stall_req <= 1'b0;
      if (empty || pop) begin
        starve <= '0;
      end else if (starve == SW'(STARVE_LIMIT-1)) begin
        stall_req <= 1'b1;
        starve    <= '0;
      end else begin
        starve <= starve + 1'b1;
      end

      wb_we <= sel_any;
      if (sel_any) begin
        wb_waddr <= sel_waddr;
        wb_wdata <= sel_wdata;
        wb_pc    <= sel_pc;
      end
    end
  end

endmodule
